ahb_sram_subordinate: RTL and testbench
=======================================

// Module: ahb_sram_subordinate
// PURPOSE
//  AHB-Lite subordinate backed by a byte-writable SRAM; the responder end of the AHB manager/subordinate bus.
//  Sits behind the address decoder (HSELx) and serves as the reference target for VIP manager/monitor checks.
//  Issues OKAY or two-cycle ERROR responses. Optionally inserts fixed wait states.
// PARAMETERS
//  ADDR_WIDTH   32     HADDR width
//  DATA_WIDTH   32     HWDATA/HRDATA width; 32 or 64 only
//  MEM_BYTES    4096   SRAM size in bytes; power of 2, multiple of DATA_WIDTH/8
//  BASE_ADDR    0      byte address of SRAM offset 0
//  WAIT_STATES  1      data-phase wait cycles per transfer; used only with AHB_SUB_WAIT_EN; range 0..15
// PORTS
//  HCLK       in   1               clock, rising edge
//  HRESET     in   1               reset: synchronous, active-high
//  HSELx      in   1               subordinate select
//  HADDR      in   ADDR_WIDTH      byte address
//  HTRANS     in   2               IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1               1 = write
//  HSIZE      in   3               transfer size, 2**HSIZE bytes
//  HBURST     in   3               burst type; ignored, transfers handled individually
//  HPROT      in   4               ignored
//  HMASTLOCK  in   1               ignored
//  HWDATA     in   DATA_WIDTH      write data; valid in data phase
//  HWSTRB     in   DATA_WIDTH/8    byte-lane write enables
//  HREADY     in   1               bus ready; an address phase is accepted only when HREADY=1
//  HRDATA     out  DATA_WIDTH      read data
//  HREADYOUT  out  1               this subordinate's ready
//  HRESP      out  1               0 = OKAY, 1 = ERROR
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, no pending transfer. SRAM contents are not reset.
//  Accept: on a HCLK edge with HSELx & HREADY & HTRANS[1], capture addr/write/size. The next cycle is the data phase.
//  IDLE/BUSY, or HSELx=0: zero-wait OKAY and no SRAM access.
//  Error (transfer discarded, no SRAM write), raised when any of these holds:
//   - offset = HADDR - BASE_ADDR >= MEM_BYTES, including HADDR < BASE_ADDR;
//   - HADDR is not aligned to 2**HSIZE;
//   - 2**HSIZE > DATA_WIDTH/8.
//  FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
//   - IDLE/DATA on a good accept -> DATA, or -> WAIT when waits are enabled and WAIT_STATES > 0.
//   - IDLE/DATA on a bad accept -> ERR1.
//   - IDLE/DATA with no accept -> IDLE.
//   - WAIT: HREADYOUT=0, HRESP=0. Count WAIT_STATES cycles, then -> DATA.
//   - DATA: HREADYOUT=1, HRESP=0. The transfer completes this cycle.
//   - ERR1: HREADYOUT=0, HRESP=1. Always -> ERR2.
//   - ERR2: HREADYOUT=1, HRESP=1. Accepts the next address phase like DATA.
//  Read: SRAM word read registered into HRDATA so it is valid in the completing data-phase cycle.
//   Zero-wait latency is 1 cycle after address accept. All lanes are driven; the manager selects by HSIZE/HADDR.
//  Write: at the completing edge of DATA, bytes with HWSTRB[i]=1 are written from HWDATA. Other bytes are unchanged.
//  Hazard: a read address phase accepted on the same edge a write completes to the same word must return merged data.
//   Merged = new bytes where HWSTRB=1, old bytes elsewhere.
//  HRDATA holds its value outside read data phases. It is 0 during error responses.
//  HRESET asserted mid-transfer: abort immediately to reset values. A pending write is dropped.
// CONFIGURATION
//  AHB_SUB_WAIT_EN defined: every accepted good transfer inserts WAIT_STATES cycles of HREADYOUT=0 before DATA.
//  AHB_SUB_WAIT_EN undefined: all good transfers are zero-wait, WAIT exists nowhere, and WAIT_STATES is ignored.
//  Error timing is identical in both builds.
// STRUCTURE
//  ahb_pkg (shared): htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), hsize_e, hburst_e, HRESP_OKAY/HRESP_ERROR.
//  FSM state enum is local to the module.
//  Sub-module ahb_sub_mem: synchronous SRAM, MEM_BYTES/(DATA_WIDTH/8) words, per-byte write enable, registered read port.
// TESTING
//  1. Reset: HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0.
//  2. Basic write/read:
//     - stimulus: write 0xDEADBEEF to 0x10 with HWSTRB=4'hF, then NONSEQ read of 0x10;
//     - response: HRDATA=0xDEADBEEF, OKAY, zero-wait.
//  3. Byte write with back-to-back hazard:
//     - stimulus: with 0x10=0xDEADBEEF, write HWSTRB=4'h2, HWDATA=0x0000AA00, and read 0x10 in the next address phase;
//     - response: HRDATA=0xDEADAAEF.
//  4. Error responses, each giving HRESP=1 for 2 cycles, HREADYOUT 0 then 1, and memory unchanged:
//     - read at BASE_ADDR+MEM_BYTES;
//     - word write at 0x02 (misaligned).
//  5. With AHB_SUB_WAIT_EN and WAIT_STATES=3:
//     - stimulus: read 0x10;
//     - response: HREADYOUT=0 for 3 cycles, then 1 with HRDATA=0xDEADBEEF.
//  6. IDLE/BUSY and HSELx=0 give no access. HRESET asserted during a WAIT cycle returns to IDLE next cycle with the write dropped.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and response constants used by the SRAM subordinate and its bench.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Low address bits that must be zero for a transfer of 2**hsize bytes.
  function automatic logic [6:0] size_mask(input logic [2:0] hsize);
    return 7'((8'd1 << hsize) - 8'd1);
  endfunction

endpackage

// File: rtl/ahb_sub_mem.sv
// Synchronous byte-writable SRAM with a registered read port; a read that hits the word
// being written on the same edge returns the merged (write-first) data.
module ahb_sub_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1024,
  parameter int AW         = $clog2(WORDS),
  parameter int NB         = DATA_WIDTH / 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NB-1:0]         wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  clr,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    merged = mem[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NB; i++) begin
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? merged : mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: OKAY or two-cycle ERROR responses, optional fixed wait states
// when AHB_SUB_WAIT_EN is defined (default build is zero-wait).
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_BYTES   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSELx,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic                    HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);

  // state  | meaning
  // S_IDLE | no transfer in data phase, ready for an address phase
  // S_DATA | completing data phase of a good transfer (write lands on this edge)
  // S_WAIT | inserted wait cycles before S_DATA (AHB_SUB_WAIT_EN only)
  // S_ERR1 | first ERROR cycle, HREADYOUT low
  // S_ERR2 | second ERROR cycle, HREADYOUT high, accepts next address phase
  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef AHB_SUB_WAIT_EN
    S_WAIT,
`endif
    S_ERR1,
    S_ERR2
  } state_e;

  localparam int NB    = DATA_WIDTH / 8;
  localparam int WORDS = MEM_BYTES / NB;
  localparam int AW    = $clog2(WORDS);
  localparam int LB    = $clog2(NB);
  localparam logic [2:0]            MAX_SIZE  = 3'(LB);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  state_e                state;
  logic                  pend_we;
  logic [AW-1:0]         pend_word;
  logic [ADDR_WIDTH:0]   offset_ext;
  logic [AW-1:0]         addr_word;
  logic                  accept;
  logic                  bad;
  logic                  mem_we;
  logic                  mem_re;
  logic                  mem_clr;
  logic                  unused_ok;
`ifdef AHB_SUB_WAIT_EN
  logic [3:0]            wait_cnt;
`endif

  // Extra top bit flags HADDR below BASE_ADDR.
  assign offset_ext = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign addr_word  = offset_ext[LB +: AW];
  assign accept     = HSELx & HREADY & HTRANS[1] & HREADYOUT;
  assign bad        = offset_ext[ADDR_WIDTH]
                    | (offset_ext[ADDR_WIDTH-1:0] >= MEM_LIMIT)
                    | (HSIZE > MAX_SIZE)
                    | (|(HADDR[6:0] & size_mask(HSIZE)));

  assign mem_we  = (state == S_DATA) & pend_we & ~HRESET;
  assign mem_re  = accept & ~bad & ~HWRITE;
  assign mem_clr = accept & bad;

  assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK, 4'(WAIT_STATES)};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      pend_we   <= 1'b0;
      pend_word <= '0;
`ifdef AHB_SUB_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
`ifdef AHB_SUB_WAIT_EN
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= S_DATA;
            HREADYOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`endif
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          if (accept && bad) begin
            state     <= S_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
            pend_we   <= 1'b0;
          end else if (accept) begin
            pend_we   <= HWRITE;
            pend_word <= addr_word;
            HRESP     <= HRESP_OKAY;
`ifdef AHB_SUB_WAIT_EN
            if (WAIT_STATES > 0) begin
              state     <= S_WAIT;
              HREADYOUT <= 1'b0;
              wait_cnt  <= 4'(WAIT_STATES - 1);
            end else begin
              state     <= S_DATA;
              HREADYOUT <= 1'b1;
            end
`else
            state     <= S_DATA;
            HREADYOUT <= 1'b1;
`endif
          end else begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            pend_we   <= 1'b0;
          end
        end
      endcase
    end
  end

  ahb_sub_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (WORDS)
  ) u_mem (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .we     (mem_we),
    .waddr  (pend_word),
    .wstrb  (HWSTRB),
    .wdata  (HWDATA),
    .re     (mem_re),
    .clr    (mem_clr),
    .raddr  (addr_word),
    .rdata  (HRDATA)
  );

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench for ahb_sram_subordinate: vector table, hand sequences and random
// transfers against a byte-array model.
module tb_ahb_sram_subordinate;
  import ahb_pkg::*;

  localparam int MEMB = 4096;
`ifdef AHB_SUB_WAIT_EN
  localparam int EXP_WAIT = 3;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = '0;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  always #5 HCLK = ~HCLK;

  ahb_sram_subordinate #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_BYTES  (MEMB),
    .BASE_ADDR  (32'h0),
    .WAIT_STATES(3)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSELx     (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HPROT     (hprot),
    .HMASTLOCK (hmastlock),
    .HWDATA    (hwdata),
    .HWSTRB    (hwstrb),
    .HREADY    (hreadyout),
    .HRDATA    (hrdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] model [MEMB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
    return (a >= 32'(MEMB)) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    int b;
    b = int'(a) / 4 * 4;
    for (int i = 0; i < 4; i++) if (st[i]) model[b + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int b;
    b = int'(a) / 4 * 4;
    return {model[b + 3], model[b + 2], model[b + 1], model[b]};
  endfunction

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (!hreadyout && guard < 40) begin
      @(negedge HCLK);
      guard++;
    end
    if (guard >= 40) begin
      total++;
      bad++;
      $display("FAIL %s timeout: HREADYOUT stayed 0 for %0d cycles", name, guard);
    end
  endtask

  // Single non-pipelined transfer; returns response shape observed in the data phase.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output int nlow,
                      output logic low_resp, output logic fin_resp);
    int guard;
    @(negedge HCLK);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = w; hsize = sz;
    @(negedge HCLK);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd; hwstrb = st;
    nlow = 0; low_resp = 1'b0; guard = 0;
    while (!hreadyout && guard < 40) begin
      nlow++;
      low_resp = low_resp | hresp;
      @(negedge HCLK);
      guard++;
    end
    if (guard >= 40) begin
      total++;
      bad++;
      $display("FAIL xfer timeout at %h: HREADYOUT low for %0d cycles", a, guard);
    end
    fin_resp = hresp;
    rd = hrdata;
  endtask

  task automatic check_xfer(input string name, input bit w, input bit err,
                            input logic [31:0] exp_rd, input logic [31:0] rd,
                            input int nlow, input logic low_resp, input logic fin_resp);
    if (err) begin
      chk({name, " err_low_cycles"}, 32'(nlow), 32'd1);
      chk({name, " err_resp1"}, {31'd0, low_resp}, 32'd1);
      chk({name, " err_resp2"}, {31'd0, fin_resp}, 32'd1);
      chk({name, " err_rdata"}, rd, 32'd0);
    end else begin
      chk({name, " wait_cycles"}, 32'(nlow), 32'(EXP_WAIT));
      chk({name, " wait_resp"}, {31'd0, low_resp}, 32'd0);
      chk({name, " resp"}, {31'd0, fin_resp}, 32'd0);
      if (!w) chk({name, " rdata"}, rd, exp_rd);
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [3:0]  st;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd, input logic [3:0] st,
                              input bit err, input logic [31:0] rd);
    vec_t v;
    v.w = w; v.a = a; v.sz = sz; v.wd = wd; v.st = st; v.err = err; v.rd = rd;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    int          nlow;
    logic        low_resp;
    logic        fin_resp;
    logic [31:0] exp_word;

    tbl.push_back(mk(1, 32'h010, 3'd2, 32'hDEADBEEF, 4'hF, 0, 32'h0));
    tbl.push_back(mk(0, 32'h010, 3'd2, 32'h0,        4'h0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 32'h000, 3'd2, 32'h11223344, 4'hF, 0, 32'h0));
    tbl.push_back(mk(0, 32'h1000, 3'd2, 32'h0,       4'h0, 1, 32'h0));
    tbl.push_back(mk(1, 32'h002, 3'd2, 32'hFFFFFFFF, 4'hF, 1, 32'h0));
    tbl.push_back(mk(0, 32'h000, 3'd2, 32'h0,        4'h0, 0, 32'h11223344));
    tbl.push_back(mk(1, 32'h020, 3'd2, 32'hA5A5A5A5, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, 32'h022, 3'd0, 32'h00CC0000, 4'h4, 0, 32'h0));
    tbl.push_back(mk(0, 32'h020, 3'd2, 32'h0,        4'h0, 0, 32'hA5CCA5A5));
    tbl.push_back(mk(0, 32'h023, 3'd1, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h018, 3'd3, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk(1, 32'hFFC, 3'd2, 32'hCAFEF00D, 4'hF, 0, 32'h0));
    tbl.push_back(mk(0, 32'hFFC, 3'd2, 32'h0,        4'h0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(0, 32'h012, 3'd1, 32'h0,        4'h0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 32'hFFFFFFFC, 3'd2, 32'h0,   4'h0, 1, 32'h0));

    // Reset
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("reset hresp", {31'd0, hresp}, 32'd0);
    chk("reset hrdata", hrdata, 32'd0);
    HRESET = 1'b0;

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, tbl[i].st, rd, nlow, low_resp, fin_resp);
      check_xfer($sformatf("vec%0d", i), tbl[i].w, tbl[i].err, tbl[i].rd, rd, nlow, low_resp, fin_resp);
      if (tbl[i].w && !tbl[i].err) model_write(tbl[i].a, tbl[i].wd, tbl[i].st);
    end

    // Back-to-back write then read of the same word
    @(negedge HCLK);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge HCLK);
    hwdata = 32'h0000AA00; hwstrb = 4'h2; hwrite = 1'b0;
    wait_ready("hazard1 write");
    @(negedge HCLK);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    wait_ready("hazard1 read");
    chk("hazard1 rdata", hrdata, 32'hDEADAAEF);
    model_write(32'h10, 32'h0000AA00, 4'h2);

    @(negedge HCLK);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge HCLK);
    hwdata = 32'h77000011; hwstrb = 4'h9; hwrite = 1'b0;
    wait_ready("hazard2 write");
    @(negedge HCLK);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    wait_ready("hazard2 read");
    model_write(32'h10, 32'h77000011, 4'h9);
    chk("hazard2 rdata", hrdata, model_read(32'h10));

    // BUSY and deselected NONSEQ: no access, HRDATA holds
    @(negedge HCLK);
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
    @(negedge HCLK);
    htrans = HTRANS_IDLE; hsel = 1'b0; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
    chk("busy hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("busy hresp", {31'd0, hresp}, 32'd0);
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    @(negedge HCLK);
    htrans = HTRANS_IDLE;
    chk("nosel hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("nosel hresp", {31'd0, hresp}, 32'd0);
    @(negedge HCLK);
    chk("hold hrdata", hrdata, 32'h77ADAA11);
    xfer(0, 32'h0, 3'd2, 32'h0, 4'h0, rd, nlow, low_resp, fin_resp);
    check_xfer("noaccess", 0, 0, 32'h11223344, rd, nlow, low_resp, fin_resp);

    // Reset during the data phase of a write drops the write
    @(negedge HCLK);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
    @(negedge HCLK);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0BADBEEF; hwstrb = 4'hF;
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("midrst hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("midrst hresp", {31'd0, hresp}, 32'd0);
    chk("midrst hrdata", hrdata, 32'd0);
    HRESET = 1'b0;
    xfer(0, 32'h0, 3'd2, 32'h0, 4'h0, rd, nlow, low_resp, fin_resp);
    check_xfer("midrst readback", 0, 0, 32'h11223344, rd, nlow, low_resp, fin_resp);

    // Random traffic against the byte-array model
    for (int a = 0; a < 256; a += 4) begin
      exp_word = $urandom;
      xfer(1, 32'(a), 3'd2, exp_word, 4'hF, rd, nlow, low_resp, fin_resp);
      model_write(32'(a), exp_word, 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      bit          w;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic [3:0]  st;
      bit          err;
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 15))
        0: a = 32'h1000 + 32'($urandom_range(0, 255));
        1: a = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
        default: ;
      endcase
      wd  = $urandom;
      st  = 4'($urandom_range(0, 15));
      err = model_err(a, sz);
      exp_word = err ? 32'h0 : model_read(a);
      xfer(w, a, sz, wd, st, rd, nlow, low_resp, fin_resp);
      check_xfer($sformatf("rnd%0d", n), w, err, exp_word, rd, nlow, low_resp, fin_resp);
      if (w && !err) model_write(a, wd, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
